// File: rtl/pc_pkg.sv
// Shared op and state encodings for the picoMIPS program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_BREL = 3'd2,
        PC_JABS = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5,
        PC_HALT = 3'd6
    } pc_op_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } pc_state_t;

    localparam int unsigned PC_OP_W = 3;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack; push/pop requests are ignored when full/empty.
module pc_ret_stack #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top_c,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full_c,
    output logic                         empty_c
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEP_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full_c  = (depth == DEP_W'(DEPTH));
    assign empty_c = (depth == '0);
    assign top_c   = mem[IDX_W'(depth - DEP_W'(1))];

    // Entry storage carries no reset; contents are meaningless below depth.
    always_ff @(posedge clk) begin
        if (push && !full_c) begin
            mem[IDX_W'(depth)] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full_c) begin
            depth <= depth + DEP_W'(1);
        end else if (pop && !empty_c) begin
            depth <= depth - DEP_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: inc/branch/jump/halt, plus call/return stack
// and stack-fault detection when built with PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned P_SIZE    = 6,
    parameter int unsigned OFF_W     = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [PC_OP_W-1:0]               op,
    input  logic [P_SIZE-1:0]                target,
    input  logic [OFF_W-1:0]                 offset,
    input  logic                             resume,
    output logic [P_SIZE-1:0]                addressOut,
    output logic                             halted,
    output logic                             fault,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   rasDepth
);

    pc_state_t         state;
    logic [P_SIZE-1:0] pc_inc_c;
    logic [P_SIZE-1:0] pc_brel_c;
    logic              exec_c;

    assign exec_c    = (state == ST_RUN) && en;
    assign pc_inc_c  = addressOut + P_SIZE'(1);
    assign pc_brel_c = addressOut + P_SIZE'($signed(offset));

`ifdef PC_RAS_EN
    logic              ras_push_c;
    logic              ras_pop_c;
    logic [P_SIZE-1:0] ras_top_c;
    logic              ras_full_c;
    logic              ras_empty_c;

    always_comb begin
        ras_push_c = 1'b0;
        ras_pop_c  = 1'b0;
        if (exec_c) begin
            ras_push_c = (op == PC_CALL) && !ras_full_c;
            ras_pop_c  = (op == PC_RET)  && !ras_empty_c;
        end
    end

    pc_ret_stack #(
        .WIDTH (P_SIZE),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_c),
        .pop       (ras_pop_c),
        .push_data (pc_inc_c),
        .top_c     (ras_top_c),
        .depth     (rasDepth),
        .full_c    (ras_full_c),
        .empty_c   (ras_empty_c)
    );
`else
    assign rasDepth = '0;
    assign fault    = 1'b0;
`endif

    // State, PC and status flags; reset dominates, HALTED/FAULT ignore en/op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            addressOut <= '0;
            halted     <= 1'b0;
`ifdef PC_RAS_EN
            fault      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (exec_c) begin
                        case (op)
                            PC_INC:  addressOut <= pc_inc_c;
                            PC_BREL: addressOut <= pc_brel_c;
                            PC_JABS: addressOut <= target;
`ifdef PC_RAS_EN
                            PC_CALL: begin
                                if (ras_full_c) begin
                                    state <= ST_FAULT;
                                    fault <= 1'b1;
                                end else begin
                                    addressOut <= target;
                                end
                            end
                            PC_RET: begin
                                if (ras_empty_c) begin
                                    state <= ST_FAULT;
                                    fault <= 1'b1;
                                end else begin
                                    addressOut <= ras_top_c;
                                end
                            end
`else
                            PC_CALL: addressOut <= target;
`endif
                            PC_HALT: begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow PC_RAS_EN.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int unsigned P_SIZE    = 6;
    localparam int unsigned OFF_W     = 4;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned DEP_W     = $clog2(RAS_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [2:0]        op;
    logic [P_SIZE-1:0] target;
    logic [OFF_W-1:0]  offset;
    logic              resume;
    logic [P_SIZE-1:0] addressOut;
    logic              halted;
    logic              fault;
    logic [DEP_W-1:0]  rasDepth;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .P_SIZE    (P_SIZE),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .op         (op),
        .target     (target),
        .offset     (offset),
        .resume     (resume),
        .addressOut (addressOut),
        .halted     (halted),
        .fault      (fault),
        .rasDepth   (rasDepth)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic s_en, input logic [2:0] s_op,
                        input int s_tgt, input int s_off);
        en     = s_en;
        op     = s_op;
        target = P_SIZE'(s_tgt);
        offset = OFF_W'(s_off);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 3'(PC_HOLD), 0, 0);
        step(1'b0, 3'(PC_HOLD), 0, 0);
        rst = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int pc, input int h,
                           input int f, input int d);
        chk({tag, ".pc"}, int'(addressOut), pc);
        chk({tag, ".halted"}, int'(halted), h);
        chk({tag, ".fault"}, int'(fault), f);
        chk({tag, ".depth"}, int'(rasDepth), d);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = '0; target = '0; offset = '0; resume = 1'b0;
        #1;
        do_reset();
        chk_all("reset", 0, 0, 0, 0);

        // Counting with wrap at 2^P_SIZE.
        for (int i = 1; i <= 70; i++) begin
            step(1'b1, 3'(PC_INC), 0, 0);
            chk("inc", int'(addressOut), i % 64);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'(PC_INC), 0, 0);
            chk("en_low_hold", int'(addressOut), 6);
        end
        step(1'b1, 3'd7, 0, 0);
        chk("reserved_hold", int'(addressOut), 6);
        step(1'b1, 3'(PC_HOLD), 0, 0);
        chk("op_hold", int'(addressOut), 6);
        step(1'b1, 3'(PC_INC), 0, 0);
        resume = 1'b1;
        step(1'b1, 3'(PC_INC), 0, 0);
        resume = 1'b0;
        chk("resume_in_run", int'(addressOut), 8);
        chk("resume_in_run.halted", int'(halted), 0);

        // Relative branches, both directions and wrapping.
        step(1'b1, 3'(PC_JABS), 10, 0);
        chk("jabs", int'(addressOut), 10);
        step(1'b1, 3'(PC_BREL), 0, 4'b1101);
        chk("brel_neg", int'(addressOut), 7);
        step(1'b1, 3'(PC_BREL), 0, 7);
        chk("brel_pos", int'(addressOut), 14);
        step(1'b1, 3'(PC_JABS), 62, 0);
        step(1'b1, 3'(PC_BREL), 0, 3);
        chk("brel_wrap_up", int'(addressOut), 1);
        step(1'b1, 3'(PC_BREL), 0, 4'b1000);
        chk("brel_wrap_down", int'(addressOut), 57);

        // Call / return.
        step(1'b1, 3'(PC_JABS), 5, 0);
        step(1'b1, 3'(PC_CALL), 20, 0);
`ifdef PC_RAS_EN
        chk_all("call1", 20, 0, 0, 1);
        step(1'b1, 3'(PC_CALL), 40, 0);
        chk_all("call2", 40, 0, 0, 2);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("ret1", 21, 0, 0, 1);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("ret2", 6, 0, 0, 0);

        step(1'b1, 3'(PC_JABS), 63, 0);
        step(1'b1, 3'(PC_CALL), 5, 0);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("ret_wrap", 0, 0, 0, 0);

        // Overflow on the fifth call freezes the sequencer.
        for (int i = 0; i < 4; i++) step(1'b1, 3'(PC_CALL), 11 + i, 0);
        chk_all("call4", 14, 0, 0, 4);
        step(1'b1, 3'(PC_CALL), 15, 0);
        chk_all("overflow", 14, 0, 1, 4);
        for (int i = 0; i < 3; i++) step(1'b1, 3'(PC_INC), 0, 0);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("fault_frozen", 14, 0, 1, 4);
        do_reset();
        chk_all("fault_reset", 0, 0, 0, 0);

        // Underflow.
        step(1'b1, 3'(PC_JABS), 9, 0);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("underflow", 9, 0, 1, 0);
        step(1'b1, 3'(PC_INC), 0, 0);
        chk_all("underflow_frozen", 9, 0, 1, 0);
        do_reset();
        chk_all("underflow_reset", 0, 0, 0, 0);
`else
        chk_all("call_as_jabs", 20, 0, 0, 0);
        step(1'b1, 3'(PC_JABS), 3, 0);
        step(1'b1, 3'(PC_CALL), 30, 0);
        chk_all("call_norass", 30, 0, 0, 0);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("ret_as_hold", 30, 0, 0, 0);
        step(1'b1, 3'(PC_RET), 0, 0);
        chk_all("ret_empty_nofault", 30, 0, 0, 0);
`endif

        // Halt / resume.
        step(1'b1, 3'(PC_JABS), 12, 0);
        step(1'b1, 3'(PC_HALT), 0, 0);
        chk_all("halt", 12, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'(PC_INC), 0, 0);
        chk_all("halted_hold", 12, 1, 0, 0);
        resume = 1'b1;
        step(1'b1, 3'(PC_INC), 0, 0);
        resume = 1'b0;
        chk_all("resume", 12, 0, 0, 0);
        step(1'b1, 3'(PC_INC), 0, 0);
        chk_all("after_resume", 13, 0, 0, 0);

        // Reset while halted.
        step(1'b1, 3'(PC_HALT), 0, 0);
        chk("halt2", int'(halted), 1);
        do_reset();
        chk_all("halt_reset", 0, 0, 0, 0);
        step(1'b1, 3'(PC_INC), 0, 0);
        chk("run_after_reset", int'(addressOut), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the picoMIPS fetch path; successor to the plain incrementing PC.
- Adds the following on top of increment/hold:
  - relative branch
  - absolute jump
  - call/return through a hardware return-address stack
  - halt/resume
  - fault detection
- Drives the instruction-memory address. Op is decoded by the control unit and presented with an enable.

Parameters:
- P_SIZE, 6, address width in bits (wrap modulo 2^P_SIZE).
- OFF_W, 4, width of the signed relative-branch offset (OFF_W <= P_SIZE).
- RAS_DEPTH, 4, return-address stack entries (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  advance strobe; when low the op is ignored and all state holds.
- op  in  3  pc_op_t operation code.
- target  in  P_SIZE  absolute address for JABS/CALL.
- offset  in  OFF_W  signed two's-complement offset for BREL.
- resume  in  1  leaves HALTED.
- addressOut  out  P_SIZE  current fetch address.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- rasDepth  out  $clog2(RAS_DEPTH+1)  entries currently on the stack.

Behaviour:
- Reset:
  - Synchronous, active-high, and takes priority over everything.
  - On the clk edge with rst=1: addressOut=0, state=RUN, halted=0, fault=0, rasDepth=0. Stack contents are don't-care.
  - A reset mid-operation (HALTED, FAULT, or during a call) discards all state.
- Latency:
  - One cycle. The op sampled on edge N (en=1, state RUN) is reflected on addressOut after edge N.
  - Outputs are registered; there is no combinational path from inputs to outputs.
- FSM states RUN, HALTED, FAULT:
  - RUN, en=0: hold everything.
  - RUN, en=1, per op:
    - HOLD (0): no change.
    - INC (1): PC+1.
    - BREL (2): PC + sign-extended offset.
    - JABS (3): PC=target.
    - CALL (4): push PC+1, then PC=target.
    - RET (5): PC=top of stack, then pop.
    - HALT (6): PC unchanged, go to HALTED.
    - 7 (reserved): treated as HOLD.
  - HALTED: addressOut held; en/op ignored. resume=1 returns to RUN on the next edge; no op executes on that edge.
  - FAULT: addressOut and stack frozen; exits only via rst.
- Arithmetic: all address arithmetic is modulo 2^P_SIZE.
  - PC=2^P_SIZE-1 with INC gives 0.
  - BREL wraps both ways.
  - The value pushed by CALL at max address is 0.
- Stack boundaries:
  - CALL with rasDepth=RAS_DEPTH (full): overflow. No push, PC unchanged, go to FAULT.
  - RET with rasDepth=0 (empty): underflow. PC unchanged, go to FAULT.
  - rasDepth never exceeds RAS_DEPTH. Stack is LIFO.
- Simultaneous events:
  - rst beats everything.
  - In HALTED, resume beats en.
  - In RUN, resume is ignored.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: return-address stack instantiated; CALL/RET and the over/underflow faults behave as above.
- Undefined:
  - No stack storage.
  - CALL behaves exactly as JABS.
  - RET behaves as HOLD.
  - rasDepth tied to 0.
  - FAULT is unreachable.
  - The fault port still exists, tied 0.

Decomposition:
- Package pc_pkg holds:
  - pc_op_t, a 3-bit enum with PC_HOLD, PC_INC, PC_BREL, PC_JABS, PC_CALL, PC_RET, PC_HALT.
  - pc_state_t enum with ST_RUN, ST_HALTED, ST_FAULT.
- Sub-module pc_ret_stack:
  - Parametrised by width and depth.
  - Provides push/pop, top, depth, full, empty, plus the same synchronous active-high reset.
  - Instantiated only under PC_RAS_EN.

Test Plan:
- P_SIZE=6. rst=1 for 2 cycles, then 70 cycles of en=1/INC → addressOut counts 0..63, wraps to 0, ends at 6. en=0 for 3 cycles holds 6.
- PC=10:
  - BREL offset=4'b1101 (-3) → 7.
  - BREL offset=7 → 14.
  - PC=62, BREL offset=3 → 1 (wrap).
- PC=5, CALL target=20 → PC=20, rasDepth=1. Then CALL target=40 → 40, depth 2. RET → 41? No: RET → 21, depth 1. RET → 6, depth 0.
- RAS_DEPTH=4: five successive CALLs → fifth sets fault=1, PC = fourth target, rasDepth=4. Subsequent INCs leave PC frozen. rst=1 clears to 0/RUN.
- RET with empty stack at PC=9 → fault=1, PC stays 9.
- HALT at PC=12 → halted=1. INC with en=1 for 3 cycles leaves 12. resume=1 → halted=0, PC 12. Next INC → 13.
- Build without PC_RAS_EN: CALL target=30 at PC=3 → 30, rasDepth=0. RET → stays 30, fault=0.
